// File: rtl/board_io_pkg.sv
// -----------------------------------------------------------------------------
// board_io_pkg
//
// Shared constants and types for the board input path.
//   N_BTN_DEFAULT        number of push-buttons on the board
//   N_SW_DEFAULT         number of slide switches on the board
//   SIM_DEBOUNCE_CYCLES  short debounce window used when simulating
//   btn_vec_t / sw_vec_t convenience vectors sized for the default board
//   cnt_width()          width needed for a debounce counter
// -----------------------------------------------------------------------------
package board_io_pkg;

    localparam int N_BTN_DEFAULT       = 5;
    localparam int N_SW_DEFAULT        = 16;
    localparam int SIM_DEBOUNCE_CYCLES = 4;

    typedef logic [N_BTN_DEFAULT-1:0] btn_vec_t;
    typedef logic [N_SW_DEFAULT-1:0]  sw_vec_t;

    // Counter must hold 0 .. debounce_cycles-1; sized for debounce_cycles
    // so a window of 1 still yields a 1-bit counter.
    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
//
// One input channel: synchronises a raw asynchronous level into clk and
// accepts a new level only after DEBOUNCE_CYCLES consecutive samples that
// differ from the current level. Emits registered one-cycle pulses on the
// same edge that updates the level.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   raw    in   raw asynchronous input
//   level  out  debounced level
//   rise   out  one-cycle pulse on debounced 0->1
//   fall   out  one-cycle pulse on debounced 1->0
// -----------------------------------------------------------------------------
module debounce_chan
    import board_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q,  cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q,  rise_d;
    logic                   fall_q,  fall_d;
    logic                   s;

    // The last synchroniser stage is the only sample the counter ever sees.
    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d   = cnt_q;
        level_d = level_q;

        // Any sample matching the current level restarts the window, so
        // the counter can never pass CNT_LAST or wrap.
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/board_input_conditioner.sv
// -----------------------------------------------------------------------------
// board_input_conditioner
//
// Conditions the board's raw push-buttons and slide switches for the CAN
// node logic: every channel is synchronised and debounced independently,
// and clean levels plus one-cycle edge pulses are presented.
//
// Ports:
//   clk          in   divided system clock
//   rst          in   synchronous active-high reset
//   btn_in       in   raw buttons, 1 = pressed
//   sw_in        in   raw switches
//   btn_level    out  debounced button levels
//   btn_press    out  one-cycle pulse per bit on debounced 0->1
//   btn_release  out  one-cycle pulse per bit on debounced 1->0
//   sw_level     out  debounced switch levels
//   sw_change    out  one-cycle pulse when any switch level updates
// -----------------------------------------------------------------------------
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int N_SW            = N_SW_DEFAULT,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_SW-1:0]  sw_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_SW-1:0]  sw_level,
    output logic             sw_change
);

    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_in[i]),
            .level(btn_level[i]),
            .rise (btn_press[i]),
            .fall (btn_release[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .raw  (sw_in[i]),
            .level(sw_level[i]),
            .rise (sw_rise[i]),
            .fall (sw_fall[i])
        );
    end

    // The per-channel pulses are already registered on the level-update
    // edge, so OR-ing them keeps sw_change aligned with sw_level and merges
    // simultaneous updates into a single pulse without adding latency.
    assign sw_change = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_board_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_board_input_conditioner
//
// Directed self-checking bench for board_input_conditioner with
// SYNC_STAGES=2 and DEBOUNCE_CYCLES=4 (level updates on edge 5 after the
// first edge that samples a new raw value).
// -----------------------------------------------------------------------------
module tb_board_input_conditioner;
    import board_io_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    btn_vec_t btn_in;
    sw_vec_t  sw_in;
    btn_vec_t btn_level;
    btn_vec_t btn_press;
    btn_vec_t btn_release;
    sw_vec_t  sw_level;
    logic     sw_change;

    int checkCount = 0;
    int passCount  = 0;

    board_input_conditioner #(
        .N_BTN          (N_BTN_DEFAULT),
        .N_SW           (N_SW_DEFAULT),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .sw_in      (sw_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .sw_level   (sw_level),
        .sw_change  (sw_change)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value and report.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance n clock edges; returns 1 ns after the last edge so outputs
    // are settled and inputs driven next are sampled by the following edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    btn_vec_t pressSeen;

    initial begin
        rst    = 1'b1;
        btn_in = '0;
        sw_in  = '0;
        applyStimulus(10);
        checkOutput("rst_btn_level",   32'(btn_level),   32'h0);
        checkOutput("rst_btn_press",   32'(btn_press),   32'h0);
        checkOutput("rst_btn_release", 32'(btn_release), 32'h0);
        checkOutput("rst_sw_level",    32'(sw_level),    32'h0);
        checkOutput("rst_sw_change",   32'(sw_change),   32'h0);
        rst = 1'b0;
        applyStimulus(3);

        // Button 0 press: level and pulse on edge 5
        btn_in[0] = 1'b1;
        applyStimulus(5);
        checkOutput("b0_level_pre",  32'(btn_level), 32'h00);
        checkOutput("b0_press_pre",  32'(btn_press), 32'h00);
        applyStimulus(1);
        checkOutput("b0_level",      32'(btn_level), 32'h01);
        checkOutput("b0_press",      32'(btn_press), 32'h01);
        applyStimulus(1);
        checkOutput("b0_press_end",  32'(btn_press), 32'h00);
        checkOutput("b0_level_hold", 32'(btn_level), 32'h01);

        // Button 0 release
        applyStimulus(3);
        btn_in[0] = 1'b0;
        applyStimulus(5);
        checkOutput("b0_rel_pre",   32'(btn_release), 32'h00);
        checkOutput("b0_lvl_pre",   32'(btn_level),   32'h01);
        applyStimulus(1);
        checkOutput("b0_rel",       32'(btn_release), 32'h01);
        checkOutput("b0_lvl_low",   32'(btn_level),   32'h00);
        applyStimulus(1);
        checkOutput("b0_rel_end",   32'(btn_release), 32'h00);

        // Button 2 glitch of 3 samples is rejected
        applyStimulus(3);
        pressSeen = '0;
        btn_in[2] = 1'b1;
        applyStimulus(3);
        btn_in[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1);
            pressSeen |= btn_press;
        end
        checkOutput("b2_glitch_level", 32'(btn_level), 32'h00);
        checkOutput("b2_glitch_press", 32'(pressSeen), 32'h00);

        // Button 2 held for exactly 4 samples is accepted
        btn_in[2] = 1'b1;
        applyStimulus(4);
        btn_in[2] = 1'b0;
        applyStimulus(1);
        checkOutput("b2_hold4_pre", 32'(btn_level), 32'h00);
        applyStimulus(1);
        checkOutput("b2_hold4_level", 32'(btn_level), 32'h04);
        checkOutput("b2_hold4_press", 32'(btn_press), 32'h04);
        applyStimulus(10);
        checkOutput("b2_back_low", 32'(btn_level), 32'h00);

        // Switch group change 0x0000 -> 0x00A5
        sw_in = 16'h00A5;
        applyStimulus(5);
        checkOutput("sw_level_pre",  32'(sw_level),  32'h0000);
        checkOutput("sw_change_pre", 32'(sw_change), 32'h0);
        applyStimulus(1);
        checkOutput("sw_level",      32'(sw_level),  32'h00A5);
        checkOutput("sw_change",     32'(sw_change), 32'h1);
        applyStimulus(1);
        checkOutput("sw_change_end", 32'(sw_change), 32'h0);
        checkOutput("sw_level_hold", 32'(sw_level),  32'h00A5);

        // Buttons 1 and 4 rise together
        btn_in = 5'b10010;
        applyStimulus(5);
        checkOutput("b14_press_pre", 32'(btn_press), 32'h00);
        applyStimulus(1);
        checkOutput("b14_press",     32'(btn_press), 32'h12);
        checkOutput("b14_level",     32'(btn_level), 32'h12);
        applyStimulus(1);
        checkOutput("b14_press_end", 32'(btn_press), 32'h00);

        // Reset during a pending change on button 3 (count at 2)
        btn_in = 5'b11010;
        applyStimulus(4);
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("mid_rst_btn_level", 32'(btn_level), 32'h00);
        checkOutput("mid_rst_btn_press", 32'(btn_press), 32'h00);
        checkOutput("mid_rst_sw_level",  32'(sw_level),  32'h0000);
        checkOutput("mid_rst_sw_change", 32'(sw_change), 32'h0);
        applyStimulus(1);
        rst = 1'b0;

        // Inputs still high: normal 0->1 events after the standard latency
        applyStimulus(5);
        checkOutput("post_rst_level_pre", 32'(btn_level), 32'h00);
        checkOutput("post_rst_sw_pre",    32'(sw_level),  32'h0000);
        applyStimulus(1);
        checkOutput("post_rst_btn_level", 32'(btn_level), 32'h1A);
        checkOutput("post_rst_btn_press", 32'(btn_press), 32'h1A);
        checkOutput("post_rst_sw_level",  32'(sw_level),  32'h00A5);
        checkOutput("post_rst_sw_change", 32'(sw_change), 32'h1);
        applyStimulus(1);
        checkOutput("post_rst_press_end", 32'(btn_press), 32'h00);
        checkOutput("post_rst_chg_end",   32'(sw_change), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
